md_seq: RTL and testbench
=========================

Name: md_seq

Overview:
- Multi-cycle sequencer for the HI/LO arithmetic resource (MULT, MULTU, DIV, DIVU), driven by the decoder's ALU2Op and RHLWr outputs.
- Accepts one operation at a time and runs an iterative shift-add multiplier or a restoring divider for WIDTH iterations.
- Stalls the pipeline while busy, then pulses a single HI/LO write.
- Sits in EXE beside the single-cycle ALU; its HI/LO outputs feed the HI/LO register file.

Parameters:
- WIDTH, 32, operand width; the product/remainder register is 2*WIDTH; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (rst==0 resets at the clock edge)
- start  in  1  request; high when an EXE instruction has RHLWr=1 and RHLSel_Wr=2'b10
- ALU2Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  in  WIDTH  rs operand (dividend / multiplicand)
- B  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  cancel in-flight operation (exception or eret_flush)
- stall_req  out  1  freeze IF/ID/EXE
- busy  out  1  operation in flight
- done  out  1  one-cycle result-valid pulse
- HLWr  out  1  HI/LO write enable, equal to done
- HI  out  WIDTH  remainder or high product
- LO  out  WIDTH  quotient or low product

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; busy=0, done=0, HLWr=0; HI=LO=0; iteration counter=0; internal registers cleared. Reset overrides everything, including mid-operation.
- FSM states: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE: when start=1 and flush=0, latch ALU2Op, A, B and go to PREP. Otherwise stay in IDLE.
- PREP:
  - Signed ops: form |A| and |B|; record sA, sB.
  - Unsigned ops: take A and B unchanged.
  - Clear the accumulator and set counter=0; go to CALC.
- CALC: one iteration per cycle; counter increments; leave after iteration WIDTH-1, i.e. exactly WIDTH cycles in CALC.
  - Multiply: if the low bit of the multiplier is 1, add the multiplicand into the upper half; then shift the 2*WIDTH product right by 1, keeping the carry.
  - Divide: shift {rem,quot} left by 1; trial-subtract the divisor from rem; if no borrow, keep the difference and set quot[0]=1.
- FIXUP:
  - MULT: negate the 64-bit product if sA^sB.
  - DIV: negate quot if sA^sB; negate rem if sA.
  - B==0 for DIV or DIVU: LO=all-ones, HI=A, regardless of sign; no trap is raised.
  - Register HI and LO, then go to DONE.
- DONE: done=1 and HLWr=1 for exactly one cycle; return to IDLE on the next edge. HI and LO hold their value until the next DONE.
- Latency: start accepted at edge E0 → done high during the cycle after edge E(WIDTH+2), i.e. 35 cycles for WIDTH=32.
- busy=1 in PREP, CALC, FIXUP and DONE.
- stall_req is combinational: (state==IDLE & start & ~flush) | state∈{PREP, CALC, FIXUP}. It is low in DONE so the issuing instruction retires in the same cycle as the HLWr pulse.
- start while busy is ignored; the pipeline guarantees this cannot occur because it is stalled.
- flush=1 at any edge: go to IDLE and suppress done/HLWr; HI/LO keep their old values.
  - flush in the DONE cycle does not retract the pulse already visible that cycle.
  - flush and start together in IDLE: flush wins; nothing is accepted.
- Overflow case 0x80000000 / -1 (DIV): LO=0x80000000, HI=0. No exception is raised.

Decomposition:
- Shared package md_defs holds:
  - ALU2Op encodings (MD_MULTU, MD_MULT, MD_DIVU, MD_DIV)
  - FSM state encoding
  - MD_ITER=WIDTH
- Sub-module md_core: 2*WIDTH accumulator, shared WIDTH+1-bit adder/subtractor, and the shift logic, controlled by op/iterate/clear.
- md_seq owns the FSM, counter, sign handling and outputs.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → done at cycle 35; HI=0xFFFFFFFE, LO=0x00000001; HLWr exactly 1 cycle; stall_req high in cycles 0–34, low in 35.
- MULT A=-3, B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- Flush at cycle 10 of a DIV → no HLWr; busy=0 the next cycle; HI/LO unchanged; a new MULTU 6*7 started immediately yields LO=42, HI=0.
- rst=0 for 1 cycle mid-CALC → all outputs 0 after the edge; a subsequent op completes correctly.
- flush and start together in IDLE → no operation accepted; stall_req=0.

Source files
------------

// File: rtl/md_defs.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operation
// encodings as driven by the decoder's ALU2Op, FSM state encoding and the
// iteration count.
package md_defs;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = MD_WIDTH;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_CALC  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } md_state_e;

    // Divide ops have ALU2Op[1] set, signed ops have ALU2Op[0] set.
    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/md_core.sv
// Iterative datapath shared by multiply and divide: a 2*WIDTH accumulator,
// one WIDTH+1-bit adder/subtractor and the per-iteration shift.
//   multiply: acc = {product_hi, multiplier/product_lo}, opnd = multiplicand
//   divide:   acc = {remainder, dividend/quotient},      opnd = divisor
module md_core
    import md_defs::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             iterate,
    input  logic             is_div,
    input  logic [WIDTH-1:0] init_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     rem_s;
    logic [WIDTH:0]     add_x, add_y, sum;

    // Shared adder: adds the multiplicand into the upper half, or
    // trial-subtracts the divisor from the left-shifted remainder.
    // Because rem < divisor before each step, the subtraction result fits
    // in WIDTH+1 signed bits and its top bit is the borrow.
    always_comb begin
        rem_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        add_x = is_div ? rem_s : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        add_y = is_div ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
        sum   = add_x + add_y + {{WIDTH{1'b0}}, is_div};
    end

    // Next accumulator value: load on clear, one shift-add or
    // shift-subtract step on iterate, otherwise hold.
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (clear) begin
            acc_d  = {{WIDTH{1'b0}}, init_lo};
            opnd_d = opnd;
        end else if (iterate) begin
            if (is_div) begin
                if (sum[WIDTH]) begin
                    acc_d = {rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                if (acc_q[0]) begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
            end
        end
    end

    // Accumulator and operand registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_q[WIDTH-1:0];

endmodule

// File: rtl/md_seq.sv
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU feeding the HI/LO register
// file. Owns the FSM, iteration counter, sign handling and result
// registers; the iterative arithmetic lives in md_core.
module md_seq
    import md_defs::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       ALU2Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic             HLWr,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER + 1);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               core_clear, core_iter;
    logic [WIDTH-1:0]   mag_a, mag_b, core_init, core_opnd;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    // Operand magnitudes; unsigned ops pass the raw operands through.
    // Multiply loads the multiplier into the low half, divide the dividend.
    always_comb begin
        mag_a     = md_is_signed(op_q) ? abs_val(a_q) : a_q;
        mag_b     = md_is_signed(op_q) ? abs_val(b_q) : b_q;
        core_init = md_is_div(op_q) ? mag_a : mag_b;
        core_opnd = md_is_div(op_q) ? mag_b : mag_a;
    end

    md_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (core_clear),
        .iterate (core_iter),
        .is_div  (md_is_div(op_q)),
        .init_lo (core_init),
        .opnd    (core_opnd),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo)
    );

    // Sign correction of the unsigned core result, plus the divide-by-zero
    // override (LO all-ones, HI = dividend) which ignores signs.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        quot   = acc_lo;
        rem    = acc_hi;
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (md_is_div(op_q)) begin
            if (md_is_signed(op_q) && (sa_q ^ sb_q)) quot = -acc_lo;
            if (md_is_signed(op_q) && sa_q)          rem  = -acc_hi;
            res_hi = rem;
            res_lo = quot;
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end
        end else begin
            if (md_is_signed(op_q) && (sa_q ^ sb_q)) prod = -{acc_hi, acc_lo};
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    // Next-state logic; flush always returns to IDLE without touching HI/LO.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        core_clear = 1'b0;
        core_iter  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d    = md_op_e'(ALU2Op);
                    a_d     = A;
                    b_d     = B;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                core_clear = 1'b1;
                sa_d       = md_is_signed(op_q) & a_q[WIDTH-1];
                sb_d       = md_is_signed(op_q) & b_q[WIDTH-1];
                cnt_d      = '0;
                state_d    = ST_CALC;
            end
            ST_CALC: begin
                core_iter = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State, operand, counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= MD_MULTU;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stall is released in DONE so the issuing instruction retires with HLWr.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        HLWr      = done;
        stall_req = ((state_q == ST_IDLE) && start && !flush) ||
                    (state_q == ST_PREP) || (state_q == ST_CALC) ||
                    (state_q == ST_FIXUP);
        HI        = hi_q;
        LO        = lo_q;
    end

endmodule

// File: tb/tb_md_seq.sv
// Scoreboard bench for md_seq: stimulus pushes expected HI/LO, a monitor
// pops and compares on every HLWr pulse.
module tb_md_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [1:0]   ALU2Op;
    logic [W-1:0] A, B;
    logic         stall_req, busy, done, HLWr;
    logic [W-1:0] HI, LO;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    res_t         exp_q[$];
    res_t         mon_e;
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] last_hi  = '0;
    logic [W-1:0] last_lo  = '0;

    md_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ALU2Op    (ALU2Op),
        .A         (A),
        .B         (B),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .HLWr      (HLWr),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every HLWr pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (HLWr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_hlwr", 64'(HLWr), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("HI", 64'(HI), 64'(mon_e.hi));
                check("LO", 64'(LO), 64'(mon_e.lo));
            end
        end
    end

    // Issue one operation (called just after a rising edge, DUT idle) and
    // follow it to completion, checking latency and handshake outputs.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int cyc;
        bit stall_ok;
        ALU2Op = op;
        A      = a;
        B      = b;
        start  = 1'b1;
        exp_q.push_back('{hi: ehi, lo: elo});
        @(negedge clk);
        check({name, "_stall_c0"}, 64'(stall_req), 64'd1);
        @(posedge clk);
        #1;
        start    = 1'b0;
        A        = $urandom;
        B        = $urandom;
        ALU2Op   = 2'($urandom);
        stall_ok = 1'b1;
        for (cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (stall_req !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
        end
        check({name, "_latency"}, 64'(cyc), 64'd35);
        check({name, "_stall_busy_run"}, 64'(stall_ok), 64'd1);
        check({name, "_stall_at_done"}, 64'(stall_req), 64'd0);
        @(negedge clk);
        check({name, "_hlwr_one_cycle"}, 64'(HLWr), 64'd0);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        last_hi = ehi;
        last_lo = elo;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        ALU2Op = 2'b00;
        A      = '0;
        B      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hlwr", 64'(HLWr), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_m3x5", 2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div_m7d2",  2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7dm2",  2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        run_op("divu_100d7",2'b10, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        run_op("div_m5d0",  2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("divu_5d0",  2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);

        // Flush a DIV during cycle 10; no result may be written.
        ALU2Op = 2'b11;
        A      = 32'd100;
        B      = 32'd3;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hlwr", 64'(HLWr), 64'd0);
        check("flush_hi_kept", 64'(HI), 64'(last_hi));
        check("flush_lo_kept", 64'(LO), 64'(last_lo));
        @(posedge clk);
        #1;
        run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42);

        // One-cycle reset in the middle of CALC.
        ALU2Op = 2'b00;
        A      = 32'h12345678;
        B      = 32'h9ABCDEF0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hlwr", 64'(HLWr), 64'd0);
        check("midrst_stall", 64'(stall_req), 64'd0);
        check("midrst_hi", 64'(HI), 64'd0);
        check("midrst_lo", 64'(LO), 64'd0);
        @(posedge clk);
        #1;
        run_op("divu_after_rst", 2'b10, 32'd1000, 32'd10, 32'd0, 32'd100);

        // flush and start together in IDLE: nothing is accepted.
        ALU2Op = 2'b00;
        A      = 32'd3;
        B      = 32'd3;
        start  = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        check("flush_start_stall", 64'(stall_req), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("flush_start_no_result_lo", 64'(LO), 64'd100);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
